scanline_feeder: RTL and testbench

- Parametrised next-generation line-buffer feeder for the CGIA dot pipeline.
- Generates line-buffer fetch addresses plus shifter load/shift strobes for one scanline.
- Adds programmable start address, line length in words, bits-per-pixel (1/2/4/8) and horizontal pixel repeat (1–4 dots).
- Sits between the scanline timing generator and the pixel shifter/line buffer.

---
 rtl/scanline_feeder.sv | 169 ++++++++++++++++
 tb/tb_scanline_feeder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_feeder.sv
// Line-buffer feeder: turns one scanline enable into fetch addresses and shifter load/shift strobes.
// All outputs registered (decoded from next state, so they describe the current cycle); no backpressure, strobes free-run on dotclk.
module scanline_feeder #(
  parameter int ADR_W   = 9,
  parameter int SHIFT_W = 16
) (
  input  logic             dotclk_i,
  input  logic             rst_ni,
  input  logic             scanline_en_i,
  input  logic [ADR_W-1:0] start_adr_i,
  input  logic [ADR_W-1:0] words_i,
  input  logic [1:0]       bpp_i,
  input  logic [1:0]       zoom_i,
  output logic             load_o,
  output logic             shift_o,
  output logic [ADR_W-1:0] f_adr_o,
  output logic             active_o,
  output logic             done_o
);

  localparam int PIX_W = $clog2(SHIFT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]       bpp;
    logic [1:0]       zoom;
    logic [ADR_W-1:0] words;
  } cfg_t;

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [1:0]       rep_cnt_q, rep_cnt_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADR_W-1:0] word_cnt_q, word_cnt_d;
  logic             load_q, load_d;
  logic             shift_q, shift_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic [ADR_W-1:0] adr_q, adr_d;

  logic [1:0]       rep_m1;
  logic [PIX_W-1:0] ppw_m1;
  logic [ADR_W-1:0] words_m1;
  logic             rep_wrap, pix_wrap, last_word, last_dot;
  logic             rep_wrap_d;

  // While idle the inputs flow straight through, so the first RUN cycle
  // is decoded with exactly the values that get latched on entry.
  always_comb begin
    cfg_d = cfg_q;
    if (state_q == IDLE) begin
      cfg_d.bpp   = bpp_i;
      cfg_d.zoom  = zoom_i;
      cfg_d.words = words_i;
    end
  end

  assign rep_m1    = cfg_d.zoom;
  assign ppw_m1    = PIX_W'((SHIFT_W >> cfg_d.bpp) - 1);
  assign words_m1  = cfg_d.words - ADR_W'(1);

  assign rep_wrap  = (rep_cnt_q == rep_m1);
  assign pix_wrap  = (pix_cnt_q == ppw_m1);
  assign last_word = (word_cnt_q == words_m1);
  assign last_dot  = rep_wrap && pix_wrap && last_word;

  always_comb begin
    state_d    = state_q;
    rep_cnt_d  = '0;
    pix_cnt_d  = '0;
    word_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (scanline_en_i) begin
          state_d = (cfg_d.words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!scanline_en_i) begin
          state_d = IDLE;
        end else if (last_dot) begin
          state_d = DONE;
        end else begin
          rep_cnt_d  = rep_wrap ? 2'd0 : rep_cnt_q + 2'd1;
          pix_cnt_d  = !rep_wrap ? pix_cnt_q :
                       (pix_wrap ? '0 : pix_cnt_q + PIX_W'(1));
          word_cnt_d = (rep_wrap && pix_wrap) ? word_cnt_q + ADR_W'(1) : word_cnt_q;
        end
      end
      DONE: begin
        if (!scanline_en_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rep_wrap_d = (rep_cnt_d == rep_m1);

  // Strobes for the coming cycle are decoded from its counters.
  always_comb begin
    load_d   = 1'b0;
    shift_d  = 1'b0;
    active_d = 1'b0;
    done_d   = 1'b0;
    adr_d    = adr_q;
    case (state_d)
      IDLE: begin
        load_d = 1'b1;
        adr_d  = start_adr_i;
      end
      RUN: begin
        active_d = 1'b1;
        shift_d  = rep_wrap_d && (pix_cnt_d < ppw_m1);
        load_d   = rep_wrap_d && (pix_cnt_d == ppw_m1) && (word_cnt_d < words_m1);
        if (state_q == IDLE) begin
          adr_d = start_adr_i + ADR_W'(1);
        end else if (load_q) begin
          adr_d = adr_q + ADR_W'(1);
        end
      end
      DONE: begin
        done_d = (state_q != DONE);
      end
      default: begin
        load_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      rep_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      adr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      rep_cnt_q  <= rep_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      load_q     <= load_d;
      shift_q    <= shift_d;
      active_q   <= active_d;
      done_q     <= done_d;
      adr_q      <= adr_d;
    end
  end

  assign load_o   = load_q;
  assign shift_o  = shift_q;
  assign active_o = active_q;
  assign done_o   = done_q;
  assign f_adr_o  = adr_q;

endmodule

// File: tb/tb_scanline_feeder.sv
// Bench for scanline_feeder: table of line configs, corner-case sequences, random lines vs arithmetic model.
module tb_scanline_feeder;

  logic       dotclk = 1'b0;
  logic       rst_ni;
  logic       scanline_en_i;
  logic [8:0] start_adr_i;
  logic [8:0] words_i;
  logic [1:0] bpp_i;
  logic [1:0] zoom_i;
  logic       load_o;
  logic       shift_o;
  logic [8:0] f_adr_o;
  logic       active_o;
  logic       done_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 dotclk = ~dotclk;

  scanline_feeder #(.ADR_W(9), .SHIFT_W(16)) dut (
    .dotclk_i      (dotclk),
    .rst_ni        (rst_ni),
    .scanline_en_i (scanline_en_i),
    .start_adr_i   (start_adr_i),
    .words_i       (words_i),
    .bpp_i         (bpp_i),
    .zoom_i        (zoom_i),
    .load_o        (load_o),
    .shift_o       (shift_o),
    .f_adr_o       (f_adr_o),
    .active_o      (active_o),
    .done_o        (done_o)
  );

  typedef struct {
    logic [8:0] start;
    logic [8:0] words;
    logic [1:0] bpp;
    logic [1:0] zoom;
    bit         jitter;
    int         run_len;
    int         loads;
    int         shifts;
    int         first_load;
    int         last_adr;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Runs one complete line from IDLE; expected per-dot outputs come from
  // dot index arithmetic (dot t -> repeat t%rep, pixel, word).
  task automatic run_line(input logic [8:0] st, input logic [8:0] wd,
                          input logic [1:0] bp, input logic [1:0] zm, input bit jit,
                          output int run_len, output int loads, output int shifts,
                          output int first_load, output int last_adr);
    int ppw, rep, n, words, r, p, w, e_shift, e_load, e_adr;
    ppw = 16 >> bp;
    rep = int'(zm) + 1;
    words = int'(wd);
    n = words * ppw * rep;
    run_len = 0; loads = 0; shifts = 0; first_load = -1; last_adr = -1;
    start_adr_i = st; words_i = wd; bpp_i = bp; zoom_i = zm; scanline_en_i = 1'b0;
    @(negedge dotclk);
    chk("idle.load", int'(load_o), 1);
    chk("idle.shift", int'(shift_o), 0);
    chk("idle.active", int'(active_o), 0);
    chk("idle.adr", int'(f_adr_o), int'(st));
    scanline_en_i = 1'b1;
    for (int t = 0; t < n; t++) begin
      @(negedge dotclk);
      r = t % rep;
      p = (t / rep) % ppw;
      w = t / (rep * ppw);
      e_shift = ((r == rep - 1) && (p < ppw - 1)) ? 1 : 0;
      e_load  = ((r == rep - 1) && (p == ppw - 1) && (w < words - 1)) ? 1 : 0;
      e_adr   = (int'(st) + 1 + w) % 512;
      chk($sformatf("run.active t=%0d", t), int'(active_o), 1);
      chk($sformatf("run.shift t=%0d", t), int'(shift_o), e_shift);
      chk($sformatf("run.load t=%0d", t), int'(load_o), e_load);
      chk($sformatf("run.adr t=%0d", t), int'(f_adr_o), e_adr);
      chk($sformatf("run.done t=%0d", t), int'(done_o), 0);
      if (active_o) run_len++;
      if (shift_o) shifts++;
      if (load_o) begin
        loads++;
        if (first_load < 0) first_load = t;
      end
      if (jit) begin
        zoom_i  = 2'($urandom_range(0, 3));
        bpp_i   = 2'($urandom_range(0, 3));
        words_i = 9'($urandom_range(0, 511));
      end
    end
    @(negedge dotclk);
    chk("done.pulse", int'(done_o), 1);
    chk("done.active", int'(active_o), 0);
    chk("done.load", int'(load_o), 0);
    chk("done.shift", int'(shift_o), 0);
    last_adr = int'(f_adr_o);
    words_i = wd; bpp_i = bp; zoom_i = zm;
    @(negedge dotclk);
    chk("done.hold_pulse", int'(done_o), 0);
    chk("done.hold_active", int'(active_o), 0);
    chk("done.hold_load", int'(load_o), 0);
    scanline_en_i = 1'b0;
    @(negedge dotclk);
    chk("back_idle.load", int'(load_o), 1);
    chk("back_idle.adr", int'(f_adr_o), int'(st));
    chk("back_idle.done", int'(done_o), 0);
  endtask

  initial begin
    int rl, ld, sh, fl, la;
    logic [8:0] rs, rw;
    logic [1:0] rb, rz;
    bit rj;

    vt[0] = '{9'h010, 9'd2, 2'd0, 2'd0, 1'b0, 32, 1, 30, 15, 'h012};
    vt[1] = '{9'h040, 9'd1, 2'd3, 2'd1, 1'b0,  4, 0,  1, -1, 'h041};
    vt[2] = '{9'h1FF, 9'd3, 2'd3, 2'd0, 1'b0,  6, 2,  3,  1, 'h002};
    vt[3] = '{9'h020, 9'd1, 2'd2, 2'd3, 1'b1, 16, 0,  3, -1, 'h021};
    vt[4] = '{9'h100, 9'd4, 2'd1, 2'd2, 1'b1, 96, 3, 28, 23, 'h104};

    rst_ni = 1'b0; scanline_en_i = 1'b0;
    start_adr_i = 9'h010; words_i = 9'd2; bpp_i = 2'd0; zoom_i = 2'd0;
    #1;
    chk("reset.load", int'(load_o), 0);
    chk("reset.shift", int'(shift_o), 0);
    chk("reset.adr", int'(f_adr_o), 0);
    chk("reset.active", int'(active_o), 0);
    chk("reset.done", int'(done_o), 0);
    @(negedge dotclk);
    rst_ni = 1'b1;
    @(negedge dotclk);
    chk("post_reset.load", int'(load_o), 1);
    chk("post_reset.adr", int'(f_adr_o), 'h010);

    for (int i = 0; i < 5; i++) begin
      run_line(vt[i].start, vt[i].words, vt[i].bpp, vt[i].zoom, vt[i].jitter, rl, ld, sh, fl, la);
      chk($sformatf("vec%0d.run_len", i), rl, vt[i].run_len);
      chk($sformatf("vec%0d.loads", i), ld, vt[i].loads);
      chk($sformatf("vec%0d.shifts", i), sh, vt[i].shifts);
      chk($sformatf("vec%0d.first_load", i), fl, vt[i].first_load);
      chk($sformatf("vec%0d.last_adr", i), la, vt[i].last_adr);
    end

    // Abort at RUN cycle 5, then restart from word 0.
    start_adr_i = 9'h010; words_i = 9'd2; bpp_i = 2'd0; zoom_i = 2'd0; scanline_en_i = 1'b0;
    @(negedge dotclk);
    scanline_en_i = 1'b1;
    repeat (6) @(negedge dotclk);
    chk("abort.pre_active", int'(active_o), 1);
    chk("abort.pre_shift", int'(shift_o), 1);
    scanline_en_i = 1'b0;
    @(negedge dotclk);
    chk("abort.active", int'(active_o), 0);
    chk("abort.load", int'(load_o), 1);
    chk("abort.shift", int'(shift_o), 0);
    chk("abort.adr", int'(f_adr_o), 'h010);
    chk("abort.done", int'(done_o), 0);
    repeat (2) begin
      @(negedge dotclk);
      chk("abort.no_done", int'(done_o), 0);
    end
    run_line(9'h010, 9'd2, 2'd0, 2'd0, 1'b0, rl, ld, sh, fl, la);
    chk("restart.run_len", rl, 32);
    chk("restart.first_load", fl, 15);

    // Zero-length line.
    start_adr_i = 9'h055; words_i = 9'd0; scanline_en_i = 1'b0;
    @(negedge dotclk);
    scanline_en_i = 1'b1;
    @(negedge dotclk);
    chk("w0.done", int'(done_o), 1);
    chk("w0.active", int'(active_o), 0);
    chk("w0.load", int'(load_o), 0);
    chk("w0.shift", int'(shift_o), 0);
    repeat (3) begin
      @(negedge dotclk);
      chk("w0.hold_done", int'(done_o), 0);
      chk("w0.hold_active", int'(active_o), 0);
      chk("w0.hold_load", int'(load_o), 0);
      chk("w0.hold_shift", int'(shift_o), 0);
      chk("w0.hold_adr", int'(f_adr_o), 'h055);
    end
    scanline_en_i = 1'b0;
    @(negedge dotclk);
    chk("w0.idle_load", int'(load_o), 1);
    chk("w0.idle_done", int'(done_o), 0);

    // Asynchronous reset in the middle of a line.
    start_adr_i = 9'h030; words_i = 9'd2; bpp_i = 2'd0; zoom_i = 2'd0;
    @(negedge dotclk);
    scanline_en_i = 1'b1;
    repeat (8) @(negedge dotclk);
    chk("arst.pre_active", int'(active_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst.load", int'(load_o), 0);
    chk("arst.shift", int'(shift_o), 0);
    chk("arst.adr", int'(f_adr_o), 0);
    chk("arst.active", int'(active_o), 0);
    chk("arst.done", int'(done_o), 0);
    scanline_en_i = 1'b0;
    @(negedge dotclk);
    chk("arst.held_active", int'(active_o), 0);
    rst_ni = 1'b1;
    @(negedge dotclk);
    chk("arst.rel_load", int'(load_o), 1);
    chk("arst.rel_adr", int'(f_adr_o), 'h030);
    chk("arst.rel_done", int'(done_o), 0);

    for (int k = 0; k < 12; k++) begin
      rs = 9'($urandom_range(0, 511));
      rw = 9'($urandom_range(1, 5));
      rb = 2'($urandom_range(0, 3));
      rz = 2'($urandom_range(0, 3));
      rj = 1'($urandom_range(0, 1));
      run_line(rs, rw, rb, rz, rj, rl, ld, sh, fl, la);
      chk($sformatf("rand%0d.run_len", k), rl, int'(rw) * (16 >> rb) * (int'(rz) + 1));
      chk($sformatf("rand%0d.loads", k), ld, int'(rw) - 1);
      chk($sformatf("rand%0d.last_adr", k), la, (int'(rs) + int'(rw)) % 512);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
